dvp_pixel_framer: RTL and testbench
===================================

# dvp_pixel_framer

Camera-side front end of the vision pipeline: samples a DVP-style sensor bus (vsync, href, data) already synchronous to the pixel-processing clock and converts it into the clean one-pixel-per-valid raster stream consumed by the line buffer. It guarantees that every emitted line has exactly IMAGE_WIDTH pixels and every completed frame has exactly IMAGE_HEIGHT lines. Short lines are padded, long lines are truncated, and malformed frames are flagged. Frame-position markers (sof/eol/eof) are added for downstream window and statistics blocks.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- IMAGE_WIDTH, 640, pixels per emitted line (≥2)
- IMAGE_HEIGHT, 480, lines per emitted frame (≥2)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  capture enable; sampled only at frame boundaries
- err_clr  in  1  synchronous clear of the sticky error flags
- cam_vsync  in  1  frame sync; high = vertical blanking pulse
- cam_href  in  1  line valid; high = cam_data carries a pixel
- cam_data  in  DATA_WIDTH  sensor pixel
- pixel_out  out  DATA_WIDTH  emitted pixel (line-buffer pixel_in)
- pixel_valid  out  1  pixel_out valid this cycle (line-buffer pixel_valid)
- sof  out  1  high with the first pixel of a frame
- eol  out  1  high with the last (IMAGE_WIDTH-th) pixel of each line
- eof  out  1  high with the last pixel of the frame; coincides with eol
- line_err  out  1  sticky: a short or long line was seen
- frame_err  out  1  sticky: vsync arrived before IMAGE_HEIGHT lines
- frame_cnt  out  16  completed frames; wraps 0xFFFF→0

## Operation
- Input stage: cam_vsync/href/data registered once (s1). vsync also registered a second time (s2) for edge detection. The FSM acts on s1 levels and s1/s2 edges.
- col counter: $clog2(IMAGE_WIDTH) bits. row counter: $clog2(IMAGE_HEIGHT) bits. Both are cleared on entry to VSYNC.
- IDLE: outputs quiet. On vsync rise with enable=1, go to VSYNC.
- VSYNC: wait for vsync fall, then go to LINE.
- LINE, href_s1=1:
  - Emit data_s1 with pixel_valid=1 and increment col.
  - sof when row=0 and col=0.
  - At col=IMAGE_WIDTH-1: assert eol, clear col, increment row. If row=IMAGE_HEIGHT-1, also assert eof, increment frame_cnt, and go to DONE. Otherwise, if href is still high next cycle, go to DROP.
- LINE, href falls with 0<col<IMAGE_WIDTH: set line_err and go to PAD.
- PAD: emit 0 with pixel_valid=1 each cycle until col reaches IMAGE_WIDTH-1. Markers on the final pad pixel follow the LINE rules. Exit to DROP if href_s1=1, otherwise to LINE (or DONE if that line ended the frame).
- DROP: discard pixels while href_s1=1 and set line_err. Covers the long-line tail and any line overlapping PAD. When href falls, go to LINE. Dropped lines are not counted.
- Early vsync: vsync rise in LINE/PAD/DROP with row≠0 or col≠0 sets frame_err. No eof is emitted and frame_cnt is unchanged. Go to VSYNC if enable=1, else IDLE. A partially emitted line is abandoned without padding.
- DONE: ignore href. On vsync rise, go to VSYNC if enable=1, else IDLE.
- err_clr clears line_err/frame_err. If a set event occurs in the same cycle, set wins.
- Deasserting enable mid-frame has no effect until the next vsync rise.

## Timing
- Reset: pixel_out=0, pixel_valid=0, sof=eol=eof=0, line_err=frame_err=0, frame_cnt=0, FSM=IDLE, counters 0, input registers 0. Reset is asynchronous, taking effect immediately, and may occur mid-line.
- Latency: a pixel on cam_data at rising edge k appears on pixel_out/pixel_valid after edge k+1 (2 cycles).
- Markers, pixel_out and pixel_valid are all registered and aligned to the same cycle. Markers are never asserted without pixel_valid.
- Throughput: at most 1 pixel/cycle, with no backpressure. The downstream block must accept every valid pixel.
- vsync edge detection adds one cycle after s1. Frame start is the first href high after vsync fall. Pixels present while vsync_s1=1 are ignored.
- pixel_out holds its last value when pixel_valid=0.

## Test plan
Bench parameters: IMAGE_WIDTH=10, IMAGE_HEIGHT=4, DATA_WIDTH=8.
- Reset: hold rst=1 for 5 cycles and drive random cam inputs → all outputs 0 and no pixel_valid.
- Clean frame: vsync pulse, then 4 lines of 10 href cycles with data 0..39 and 5-cycle gaps → 40 valid pixels 0..39 in order. sof with 0, eol with 9/19/29/39, eof with 39, frame_cnt=1, both error flags 0.
- Short line: line 1 carries only pixels 10..16 → emitted 10..16 then three 0x00, eol on the third pad, line_err=1. Frame still 40 pixels, eof with 39, frame_cnt=1.
- Long line: line 2 carries 12 pixels 20..31 → 20..29 emitted, eol on 29, 30/31 dropped, line_err=1. Line 3 is emitted intact.
- Early vsync after 2 lines → frame_err=1, no eof, frame_cnt unchanged. A following clean frame emits 40 pixels and frame_cnt increments. Pulse err_clr → both flags 0.
- rst pulsed mid line 1 → outputs 0 immediately. After release, pixels are ignored until the next vsync pulse. With enable=0 at the vsync rise, the whole frame produces no pixel_valid.

Source files
------------

// File: rtl/dvp_pixel_framer.sv
// dvp_pixel_framer: turns a DVP sensor bus (vsync/href/data, already in the
// pixel clock domain) into a fixed-geometry raster stream. Every emitted line
// carries exactly IMAGE_WIDTH pixels and every completed frame carries exactly
// IMAGE_HEIGHT lines. Short lines are zero padded and long lines truncated;
// anomalies are recorded in sticky error flags.
module dvp_pixel_framer #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  err_clr,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic [DATA_WIDTH-1:0] cam_data,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  pixel_valid,
  output logic                  sof,
  output logic                  eol,
  output logic                  eof,
  output logic                  line_err,
  output logic                  frame_err,
  output logic [15:0]           frame_cnt
);

  localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_LINE, S_PAD, S_DROP, S_DONE
  } state_t;

  state_t state, state_d;

  logic                  vsync_s1, vsync_s2, href_s1;
  logic [DATA_WIDTH-1:0] data_s1;
  logic [CW-1:0]         col, col_d;
  logic [RW-1:0]         row, row_d;

  logic vsync_rise, vsync_fall, in_frame, abort;
  logic pix_line, pix_pad, emit, line_end, frame_end;
  logic line_err_set, frame_err_set;

  assign vsync_rise = vsync_s1 & ~vsync_s2;
  assign vsync_fall = ~vsync_s1 & vsync_s2;

  // Shared decode: which pixel (if any) goes out this cycle and whether it
  // closes a line or the whole frame.
  always_comb begin
    in_frame  = (state == S_LINE) || (state == S_PAD) || (state == S_DROP);
    abort     = in_frame & vsync_rise;
    pix_line  = (state == S_LINE) & href_s1 & ~vsync_s1;
    pix_pad   = (state == S_PAD) & ~vsync_s1;
    emit      = pix_line | pix_pad;
    line_end  = emit & (col == COL_LAST);
    frame_end = line_end & (row == ROW_LAST);
  end

  // Input stage: one register for the bus, a second vsync tap for edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_s1 <= 1'b0;
      vsync_s2 <= 1'b0;
      href_s1  <= 1'b0;
      data_s1  <= '0;
    end else begin
      vsync_s1 <= cam_vsync;
      vsync_s2 <= vsync_s1;
      href_s1  <= cam_href;
      data_s1  <= cam_data;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state logic. At a line end the raw cam_href is next cycle's href_s1,
  // so it tells us whether the sensor line runs on past IMAGE_WIDTH.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (vsync_rise && enable) state_d = S_VSYNC;
      S_VSYNC: if (vsync_fall) state_d = S_LINE;
      S_LINE: begin
        if (abort)                       state_d = enable ? S_VSYNC : S_IDLE;
        else if (line_end)               state_d = frame_end ? S_DONE : (cam_href ? S_DROP : S_LINE);
        else if (!href_s1 && col != '0)  state_d = S_PAD;
      end
      S_PAD: begin
        if (abort)         state_d = enable ? S_VSYNC : S_IDLE;
        else if (line_end) state_d = frame_end ? S_DONE : (href_s1 ? S_DROP : S_LINE);
      end
      S_DROP: begin
        if (abort)         state_d = enable ? S_VSYNC : S_IDLE;
        else if (!href_s1) state_d = S_LINE;
      end
      S_DONE:  if (vsync_rise) state_d = enable ? S_VSYNC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter updates and error-set events.
  always_comb begin
    col_d = col;
    row_d = row;
    if (state_d == S_VSYNC) begin
      col_d = '0;
      row_d = '0;
    end else if (emit) begin
      if (line_end) begin
        col_d = '0;
        row_d = row + RW'(1);
      end else begin
        col_d = col + CW'(1);
      end
    end
    line_err_set  = ((state == S_LINE) && !abort && !vsync_s1 && !href_s1 && col != '0) ||
                    ((state == S_DROP) && href_s1);
    frame_err_set = abort && (row != '0 || col != '0);
  end

  // Registered outputs, counters and sticky flags (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      eof         <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      col         <= col_d;
      row         <= row_d;
      pixel_valid <= emit;
      sof         <= emit && row == '0 && col == '0;
      eol         <= line_end;
      eof         <= frame_end;
      if (emit)      pixel_out <= pix_pad ? '0 : data_s1;
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
      line_err    <= line_err_set  | (line_err  & ~err_clr);
      frame_err   <= frame_err_set | (frame_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_dvp_pixel_framer.sv
// Bench for dvp_pixel_framer: directed frames plus randomized frames, checked
// against a line-level reference model that predicts the emitted stream.
module tb_dvp_pixel_framer;
  localparam int DW = 8;
  localparam int W  = 10;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0, err_clr = 1'b0;
  logic          cam_vsync = 1'b0, cam_href = 1'b0;
  logic [DW-1:0] cam_data = '0;
  logic [DW-1:0] pixel_out;
  logic          pixel_valid, sof, eol, eof, line_err, frame_err;
  logic [15:0]   frame_cnt;

  dvp_pixel_framer #(.DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid), .sof(sof), .eol(eol), .eof(eof),
    .line_err(line_err), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic s, l, f;
  } beat_t;

  int    n_assert = 0;
  int    n_fail   = 0;
  beat_t expq[$];
  beat_t mon_e;
  beat_t b;
  bit    mon_on = 1'b0;

  // Reference model state: whether the current frame is being captured,
  // lines completed so far, and the expected flags / frame count.
  bit armed, m_partial, exp_line_err, exp_frame_err;
  int m_row, exp_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream scoreboard: every valid pixel must match the next predicted beat.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      n_assert++;
      if (pixel_valid) begin
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra: got pix=%h sof=%b eol=%b eof=%b, required no pixel",
                   pixel_out, sof, eol, eof);
        end else begin
          mon_e = expq.pop_front();
          if ({pixel_out, sof, eol, eof} !== mon_e) begin
            n_fail++;
            $display("FAIL stream_beat: got pix=%h sof=%b eol=%b eof=%b, required pix=%h sof=%b eol=%b eof=%b",
                     pixel_out, sof, eol, eof, mon_e.d, mon_e.s, mon_e.l, mon_e.f);
          end
        end
      end else if ({sof, eol, eof} !== 3'b000) begin
        n_fail++;
        $display("FAIL marker_no_valid: got sof=%b eol=%b eof=%b, required 000", sof, eol, eof);
      end
    end
  end

  task automatic model_reset();
    expq.delete();
    armed = 0; m_partial = 0; m_row = 0;
    exp_line_err = 0; exp_frame_err = 0; exp_cnt = 0;
  endtask

  // Vertical sync pulse; the frame is captured only if enable is high.
  task automatic vsync_pulse();
    if (armed && m_partial) exp_frame_err = 1;
    armed = enable; m_row = 0; m_partial = 0;
    cam_href = 0; cam_vsync = 1;
    repeat (3) tick();
    cam_vsync = 0;
    repeat (3) tick();
  endtask

  // One sensor line of n pixels followed by a gap. The model emits the first
  // W pixels, pads short lines with zeros, and counts the line toward the frame.
  task automatic send_line(input int n, input int base, input bit rnd, input int gap);
    bit cap, lst;
    cap = armed && (m_row < H);
    lst = (m_row == H - 1);
    for (int i = 0; i < n; i++) begin
      cam_href = 1;
      cam_data = rnd ? DW'($urandom) : DW'(base + i);
      if (cap && i < W) begin
        b = {cam_data, (m_row == 0 && i == 0), (i == W - 1), (lst && i == W - 1)};
        expq.push_back(b);
      end
      tick();
    end
    if (cap) begin
      for (int i = n; i < W; i++) begin
        b = {DW'(0), 1'b0, (i == W - 1), (lst && i == W - 1)};
        expq.push_back(b);
      end
      if (n < W || (n > W && !lst)) exp_line_err = 1;
      m_row++;
      if (m_row == H) begin
        exp_cnt = (exp_cnt + 1) & 16'hFFFF;
        m_partial = 0;
      end else begin
        m_partial = 1;
      end
    end
    cam_href = 0;
    for (int i = 0; i < gap; i++) begin
      cam_data = DW'($urandom);
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      cam_vsync = 1'($urandom); cam_href = 1'($urandom); cam_data = DW'($urandom);
      enable = 1'($urandom); err_clr = 1'($urandom);
      tick();
      n_assert++;
      if ({pixel_out, pixel_valid, sof, eol, eof, line_err, frame_err, frame_cnt} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got pix=%h vld=%b sof=%b eol=%b eof=%b lerr=%b ferr=%b cnt=%0d, required all 0",
                 pixel_out, pixel_valid, sof, eol, eof, line_err, frame_err, frame_cnt);
      end
    end
    cam_vsync = 0; cam_href = 0; cam_data = '0; enable = 0; err_clr = 0;
    tick();
    rst = 0;
    model_reset();
    mon_on = 1;
    tick();
  endtask

  task automatic test_clean_frame();
    enable = 1;
    vsync_pulse();
    for (int l = 0; l < H; l++) send_line(W, l * W, 0, 5);
    repeat (3) tick();
    n_assert++;
    if (expq.size() != 0) begin n_fail++; $display("FAIL clean_count: %0d pixels missing, required 0", expq.size()); end
    n_assert++;
    if (frame_cnt !== 16'(exp_cnt) || exp_cnt != 1) begin n_fail++; $display("FAIL clean_frame_cnt: got %0d, required 1", frame_cnt); end
    n_assert++;
    if ({line_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL clean_flags: got %b%b, required 00", line_err, frame_err); end
  endtask

  task automatic test_short_line();
    vsync_pulse();
    send_line(W, 0, 0, 5);
    send_line(7, 10, 0, 5);
    send_line(W, 20, 0, 5);
    send_line(W, 30, 0, 5);
    repeat (3) tick();
    n_assert++;
    if (expq.size() != 0) begin n_fail++; $display("FAIL short_count: %0d pixels missing, required 0", expq.size()); end
    n_assert++;
    if (line_err !== 1'b1) begin n_fail++; $display("FAIL short_line_err: got %b, required 1", line_err); end
    n_assert++;
    if (frame_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL short_frame_cnt: got %0d, required %0d", frame_cnt, exp_cnt); end
    err_clr = 1; tick(); err_clr = 0; exp_line_err = 0; exp_frame_err = 0; tick();
    n_assert++;
    if ({line_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL short_err_clr: got %b%b, required 00", line_err, frame_err); end
  endtask

  task automatic test_long_line();
    vsync_pulse();
    send_line(W, 0, 0, 5);
    send_line(W, 10, 0, 5);
    send_line(12, 20, 0, 5);
    send_line(W, 30, 0, 5);
    repeat (3) tick();
    n_assert++;
    if (expq.size() != 0) begin n_fail++; $display("FAIL long_count: %0d pixels missing, required 0", expq.size()); end
    n_assert++;
    if ({line_err, frame_err} !== 2'b10) begin n_fail++; $display("FAIL long_flags: got %b%b, required 10", line_err, frame_err); end
    n_assert++;
    if (frame_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL long_frame_cnt: got %0d, required %0d", frame_cnt, exp_cnt); end
    err_clr = 1; tick(); err_clr = 0; exp_line_err = 0; tick();
  endtask

  task automatic test_early_vsync();
    int cnt0;
    cnt0 = exp_cnt;
    vsync_pulse();
    send_line(W, 100, 0, 5);
    send_line(W, 110, 0, 5);
    vsync_pulse();
    n_assert++;
    if ({line_err, frame_err} !== 2'b01) begin n_fail++; $display("FAIL early_flags: got %b%b, required 01", line_err, frame_err); end
    n_assert++;
    if (frame_cnt !== 16'(cnt0)) begin n_fail++; $display("FAIL early_frame_cnt: got %0d, required %0d", frame_cnt, cnt0); end
    for (int l = 0; l < H; l++) send_line(W, 50 + l * W, 0, 5);
    repeat (3) tick();
    n_assert++;
    if (frame_cnt !== 16'(cnt0 + 1)) begin n_fail++; $display("FAIL early_next_cnt: got %0d, required %0d", frame_cnt, cnt0 + 1); end
    n_assert++;
    if (expq.size() != 0) begin n_fail++; $display("FAIL early_count: %0d pixels missing, required 0", expq.size()); end
    err_clr = 1; tick(); err_clr = 0; exp_line_err = 0; exp_frame_err = 0; tick();
    n_assert++;
    if ({line_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL early_err_clr: got %b%b, required 00", line_err, frame_err); end
  endtask

  task automatic test_random_frames();
    int nl;
    for (int f = 0; f < 15; f++) begin
      enable = ($urandom_range(0, 3) != 0);
      vsync_pulse();
      nl = ($urandom_range(0, 9) < 6) ? H : $urandom_range(1, H + 1);
      for (int l = 0; l < nl; l++) send_line($urandom_range(W - 3, W + 3), 0, 1, W + 2);
      n_assert++;
      if (expq.size() != 0) begin n_fail++; $display("FAIL rand_count f%0d: %0d pixels missing, required 0", f, expq.size()); end
      n_assert++;
      if ({line_err, frame_err} !== {exp_line_err, exp_frame_err}) begin
        n_fail++; $display("FAIL rand_flags f%0d: got %b%b, required %b%b", f, line_err, frame_err, exp_line_err, exp_frame_err);
      end
      n_assert++;
      if (frame_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL rand_frame_cnt f%0d: got %0d, required %0d", f, frame_cnt, exp_cnt); end
      if ($urandom_range(0, 2) == 0) begin
        err_clr = 1; tick(); err_clr = 0; exp_line_err = 0; exp_frame_err = 0; tick();
      end
    end
  endtask

  task automatic test_midline_reset();
    enable = 1;
    vsync_pulse();
    send_line(W, 0, 0, 5);
    for (int i = 0; i < 5; i++) begin
      cam_href = 1; cam_data = DW'(10 + i);
      b = {cam_data, 1'b0, 1'b0, 1'b0};
      expq.push_back(b);
      tick();
    end
    rst = 1;
    #1;
    n_assert++;
    if ({pixel_out, pixel_valid, sof, eol, eof, line_err, frame_err, frame_cnt} !== '0) begin
      n_fail++;
      $display("FAIL midline_reset_async: got pix=%h vld=%b cnt=%0d lerr=%b ferr=%b, required all 0",
               pixel_out, pixel_valid, frame_cnt, line_err, frame_err);
    end
    model_reset();
    tick(); tick();
    rst = 0;
    send_line(5, 15, 0, 5);
    send_line(W, 20, 0, 5);
    send_line(W, 30, 0, 5);
    enable = 0;
    vsync_pulse();
    for (int l = 0; l < H; l++) send_line(W, l * W, 1, 5);
    n_assert++;
    if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL disabled_frame_cnt: got %0d, required 0", frame_cnt); end
    n_assert++;
    if ({line_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL disabled_flags: got %b%b, required 00", line_err, frame_err); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_clean_frame();
    test_short_line();
    test_long_line();
    test_early_vsync();
    test_random_frames();
    test_midline_reset();
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
